// File: rtl/glyph_streamer.sv
// glyph_streamer: queues ASCII bytes, fetches 5x7 glyphs from char_rom
// and streams their 35 pixels over a valid/ready link.
module glyph_streamer #(
  parameter int         DEPTH      = 4,
  parameter int         SERPENTINE = 0,
  parameter logic [6:0] SUBST      = 7'h3F
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             char_data,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic                   abort,
  output logic [6:0]             rom_addr,
  input  logic [34:0]            rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_on,
  output logic [2:0]             pix_row,
  output logic [2:0]             pix_col,
  output logic                   pix_last,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nx;
  logic [LW-1:0] level;
  logic [LW-1:0] level_pop;
  logic [LW-1:0] level_nx;
  logic          push;
  logic          pop;
  logic [7:0]    head_nx;
  logic [34:0]   glyph;
  logic [2:0]    row;
  logic [2:0]    col;
  logic [2:0]    pcol;
  logic [5:0]    pidx;
  logic          take;
  logic          at_end;

  function automatic logic [6:0] map_addr(input logic [7:0] b);
    return (!b[7] && (b[6] || b[5])) ? b[6:0] : SUBST;
  endfunction

  assign char_ready = level != LW'(DEPTH);
  assign push       = char_valid && char_ready && !abort;
  assign pop        = (state == FETCH) && !abort;
  assign rd_nx      = rd_ptr + AW'(pop);
  assign level_pop  = level - LW'(pop);
  assign level_nx   = level_pop + LW'(push);

  // An empty FIFO receiving a byte exposes that byte as the new head
  assign head_nx = (push && level_pop == '0) ? char_data : mem[rd_nx];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rom_addr <= SUBST;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rom_addr <= SUBST;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nx;
      level  <= level_nx;
      if (level_nx != '0) rom_addr <= map_addr(head_nx);
    end
  end

  assign take   = (state == STREAM) && pix_ready;
  assign at_end = (row == 3'd6) && (col == 3'd4);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (level != '0) state_nx = FETCH;
      FETCH:   state_nx = STREAM;
      STREAM:  if (take && at_end)
                 state_nx = (level != '0) ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      glyph <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        row <= '0;
        col <= '0;
      end else if (state == FETCH) begin
        glyph <= rom_data;
        row   <= '0;
        col   <= '0;
      end else if (take) begin
        if (col == 3'd4) begin
          col <= '0;
          row <= at_end ? 3'd0 : row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  // Zig-zag wiring reads odd rows mirrored; reported col stays in emit order
  assign pcol = (SERPENTINE != 0 && row[0]) ? 3'd4 - col : col;
  assign pidx = 6'd34 - (6'(row) * 6'd5 + 6'(pcol));

  assign pix_valid  = state == STREAM;
  assign pix_on     = pix_valid && glyph[pidx];
  assign pix_last   = pix_valid && at_end;
  assign pix_row    = row;
  assign pix_col    = col;
  assign busy       = (level != '0) || (state != IDLE);
  assign fifo_level = level;

endmodule

// File: tb/tb_glyph_streamer.sv
// tb_glyph_streamer: scoreboard bench for glyph_streamer in linear
// and serpentine builds driven from shared stimulus.
module tb_glyph_streamer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        abort = 1'b0;
  logic        pix_ready = 1'b0;
  logic [34:0] glyph_model = '0;

  logic        char_ready, pix_valid, pix_on, pix_last, busy;
  logic [6:0]  rom_addr;
  logic [34:0] rom_data;
  logic [2:0]  pix_row, pix_col;
  logic [2:0]  fifo_level;

  logic        s_char_ready, s_pix_valid, s_pix_on, s_pix_last, s_busy;
  logic [6:0]  s_rom_addr;
  logic [34:0] s_rom_data;
  logic [2:0]  s_pix_row, s_pix_col;
  logic [2:0]  s_fifo_level;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int last_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sexp_q[$];
  logic [6:0] addr_q[$];

  logic [7:0] held_val;
  bit         held = 0;
  bit         new_glyph = 1;
  logic [6:0] prev_addr;

  always #5 clk = ~clk;

  assign rom_data   = glyph_model;
  assign s_rom_data = glyph_model;

  glyph_streamer #(.DEPTH(DEPTH), .SERPENTINE(0), .SUBST(7'h3F)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_on(pix_on), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .busy(busy), .fifo_level(fifo_level)
  );

  glyph_streamer #(.DEPTH(DEPTH), .SERPENTINE(1), .SUBST(7'h3F)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .char_data(char_data), .char_valid(char_valid),
    .char_ready(s_char_ready), .abort(abort),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .pix_valid(s_pix_valid), .pix_ready(pix_ready),
    .pix_on(s_pix_on), .pix_row(s_pix_row), .pix_col(s_pix_col),
    .pix_last(s_pix_last), .busy(s_busy), .fifo_level(s_fifo_level)
  );

  // Expected pixel packed as {on, last, row, col}
  function automatic logic [7:0] model_pix(input logic [34:0] g,
                                           input bit serp,
                                           input int e);
    int r, c, pc;
    r  = e / 5;
    c  = e % 5;
    pc = (serp && (r % 2 == 1)) ? 4 - c : c;
    return {g[34 - (r * 5 + pc)], e == 34, 3'(r), 3'(c)};
  endfunction

  function automatic logic [6:0] exp_addr(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7F) ? b[6:0] : 7'h3F;
  endfunction

  always @(negedge clk) begin : mon_main
    logic [7:0] got, want;
    logic [6:0] wa;
    got = {pix_on, pix_last, pix_row, pix_col};
    if (!rst_n || abort) begin
      exp_q.delete();
      addr_q.delete();
      held = 0;
      new_glyph = 1;
    end else begin
      if (held) begin
        checks++;
        if (pix_valid !== 1'b1 || got !== held_val) begin
          errors++;
          $display("FAIL hold: got v=%b px=%h required v=1 px=%h",
                   pix_valid, got, held_val);
        end
      end
      if (pix_valid && new_glyph) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL glyph_start: got unexpected glyph required none");
        end else begin
          wa = addr_q.pop_front();
          if (prev_addr !== wa) begin
            errors++;
            $display("FAIL fetch_addr: got %h required %h", prev_addr, wa);
          end
        end
        new_glyph = 0;
      end
      if (pix_valid && pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: got %h required no pixel", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL pixel: got %h required %h", got, want);
          end
        end
        acc_cnt++;
        if (pix_last) begin
          last_cnt++;
          new_glyph = 1;
        end
      end
      held = pix_valid && !pix_ready;
      held_val = got;
    end
    prev_addr = rom_addr;
  end

  always @(negedge clk) begin : mon_serp
    logic [7:0] got, want;
    got = {s_pix_on, s_pix_last, s_pix_row, s_pix_col};
    if (!rst_n || abort) begin
      sexp_q.delete();
    end else if (s_pix_valid && pix_ready) begin
      checks++;
      if (sexp_q.size() == 0) begin
        errors++;
        $display("FAIL serp_pixel: got %h required no pixel", got);
      end else begin
        want = sexp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL serp_pixel: got %h required %h", got, want);
        end
      end
    end
  end

  task automatic push_char(input logic [7:0] b);
    int n = 0;
    char_data  = b;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got char_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    for (int e = 0; e < 35; e++) begin
      exp_q.push_back(model_pix(glyph_model, 1'b0, e));
      sexp_q.push_back(model_pix(glyph_model, 1'b1, e));
    end
    addr_q.push_back(exp_addr(b));
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0 || sexp_q.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0 || sexp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got busy=%b left=%0d required busy=0 left=0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({char_ready, pix_valid, pix_on, pix_last, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 10000",
               {char_ready, pix_valid, pix_on, pix_last, busy});
    end
    checks++;
    if ({pix_row, pix_col, fifo_level} !== 9'd0) begin
      errors++;
      $display("FAIL reset_pos: got %h required 0",
               {pix_row, pix_col, fifo_level});
    end
    checks++;
    if (rom_addr !== 7'h3F) begin
      errors++;
      $display("FAIL reset_addr: got %h required 3f", rom_addr);
    end
    checks++;
    if ({s_pix_valid, s_busy, s_rom_addr} !== {2'b00, 7'h3F}) begin
      errors++;
      $display("FAIL reset_serp: got %h required 3f",
               {s_pix_valid, s_busy, s_rom_addr});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_glyph();
    int n;
    int a0, l0;
    glyph_model = 35'h4_0000_0001;
    pix_ready = 1'b1;
    a0 = acc_cnt;
    l0 = last_cnt;
    push_char(8'h41);
    n = 1;
    @(negedge clk);
    while (!pix_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency: got %0d required 3", n);
    end
    @(posedge clk);
    #1;
    wait_drain(200);
    checks++;
    if (acc_cnt - a0 != 35 || last_cnt - l0 != 1) begin
      errors++;
      $display("FAIL single_count: got %0d/%0d required 35/1",
               acc_cnt - a0, last_cnt - l0);
    end
  endtask

  task automatic test_addr_map();
    logic [7:0] bytes [6];
    bytes = '{8'h07, 8'hC1, 8'h7F, 8'h20, 8'h1F, 8'h80};
    glyph_model = 35'h2_AAAA_5555;
    pix_ready = 1'b1;
    foreach (bytes[i]) push_char(bytes[i]);
    wait_drain(800);
  endtask

  task automatic test_serpentine();
    int e = 0;
    int se = -1;
    int me = -1;
    logic [2:0] sr = 3'd7;
    logic [2:0] sc = 3'd7;
    glyph_model = '0;
    glyph_model[25] = 1'b1;
    pix_ready = 1'b1;
    push_char(8'h41);
    for (int n = 0; n < 100 && e < 35; n++) begin
      if (s_pix_valid) begin
        if (s_pix_on) begin
          se = e;
          sr = s_pix_row;
          sc = s_pix_col;
        end
        if (pix_on) me = e;
        e++;
      end
      if (e < 35) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (se != 5 || sr !== 3'd1 || sc !== 3'd0) begin
      errors++;
      $display("FAIL serp_pos: got e=%0d r=%0d c=%0d required e=5 r=1 c=0",
               se, sr, sc);
    end
    checks++;
    if (me != 9) begin
      errors++;
      $display("FAIL linear_pos: got e=%0d required e=9", me);
    end
    wait_drain(100);
    glyph_model = 35'h0_3000_0000;
    push_char(8'h52);
    wait_drain(200);
  endtask

  task automatic test_fill();
    glyph_model = 35'h6_1234_5678;
    pix_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_char(8'h30 + 8'(i));
    checks++;
    if (char_ready !== 1'b0 || fifo_level !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL fill: got ready=%b level=%0d required ready=0 level=%0d",
               char_ready, fifo_level, DEPTH);
    end
    char_data = 8'h99;
    char_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    char_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'(DEPTH) || pix_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: got level=%0d v=%b busy=%b required %0d 1 1",
               fifo_level, pix_valid, busy, DEPTH);
    end
    pix_ready = 1'b1;
    wait_drain(500);
  endtask

  task automatic test_stalls();
    int n = 0;
    int cyc = 0;
    int a0, l0;
    logic pv;
    glyph_model = 35'h5_A5C3_1E97;
    pix_ready = 1'b0;
    push_char(8'h41);
    push_char(8'h42);
    push_char(8'h43);
    a0 = acc_cnt;
    l0 = last_cnt;
    while (n < 105 && cyc < 3000) begin
      pv = pix_valid;
      pix_ready = ($urandom_range(0, 2) != 0);
      if (pv && pix_ready) n++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got busy=%b v=%b required 0 0", busy, pix_valid);
    end
    checks++;
    if (acc_cnt - a0 != 105) begin
      errors++;
      $display("FAIL accepts: got %0d required 105", acc_cnt - a0);
    end
    checks++;
    if (last_cnt - l0 != 3) begin
      errors++;
      $display("FAIL last_pulses: got %0d required 3", last_cnt - l0);
    end
    pix_ready = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_abort();
    int n = 0;
    glyph_model = 35'h7_0F0F_0F0F;
    pix_ready = 1'b1;
    push_char(8'h41);
    push_char(8'h42);
    push_char(8'h43);
    while (!(pix_valid && pix_row == 3'd3 && pix_col == 3'd2) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(pix_valid && pix_row == 3'd3 && pix_col == 3'd2)) begin
      errors++;
      $display("FAIL abort_reach: got r=%0d c=%0d required r=3 c=2",
               pix_row, pix_col);
    end
    abort = 1'b1;
    char_valid = 1'b1;
    char_data = 8'h55;
    @(posedge clk);
    #1;
    abort = 1'b0;
    char_valid = 1'b0;
    checks++;
    if ({pix_valid, busy, fifo_level} !== 5'b00000) begin
      errors++;
      $display("FAIL abort_flush: got v=%b busy=%b level=%0d required 0 0 0",
               pix_valid, busy, fifo_level);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got busy=%b/%b required 0/0", busy, s_busy);
    end
    push_char(8'h44);
    wait_drain(200);
  endtask

  task automatic test_async_reset();
    glyph_model = 35'h3_FFFF_FFFF;
    pix_ready = 1'b1;
    push_char(8'h41);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({char_ready, pix_valid, pix_on, pix_last, busy} !== 5'b10000 ||
        fifo_level !== 3'd0 || rom_addr !== 7'h3F) begin
      errors++;
      $display("FAIL async_reset: got %b lvl=%0d addr=%h required 10000 0 3f",
               {char_ready, pix_valid, pix_on, pix_last, busy},
               fifo_level, rom_addr);
    end
    checks++;
    if ({pix_row, pix_col} !== 6'd0) begin
      errors++;
      $display("FAIL async_pos: got %h required 0", {pix_row, pix_col});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got v=%b busy=%b required 0 0", pix_valid, busy);
    end
    push_char(8'h21);
    wait_drain(200);
  endtask

  initial begin
    test_reset();
    test_single_glyph();
    test_addr_map();
    test_serpentine();
    test_fill();
    test_stalls();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
